// File: rtl/ex_stage_slice.sv
// Execute slice of the RV32I pipeline: ID/EX register, forwarding, ALU, branch/jump
// resolution and the EX/MEM register.
module ex_stage_slice #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned INST_ADDR_WIDTH     = 32,
    parameter int unsigned REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic                           flush_ID_EX,
    input  logic [INST_ADDR_WIDTH-1:0]     PC_ID,
    input  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID,
    input  logic [DATA_WIDTH-1:0]          imm_ID,
    input  logic [DATA_WIDTH-1:0]          RD1D_ID,
    input  logic [DATA_WIDTH-1:0]          RD2D_ID,
    input  logic                           reg_write_ID,
    input  logic                           mem_write_ID,
    input  logic                           meet_branch_ID,
    input  logic                           pc_jal_sel_ID,
    input  logic [1:0]                     result_sel_ID,
    input  logic [1:0]                     uncond_jump_ID,
    input  logic [1:0]                     alu_sel_rs1_ID,
    input  logic [1:0]                     alu_sel_rs2_ID,
    input  logic [3:0]                     alu_ctrl_ID,
    input  logic [2:0]                     funct3_ID,
    input  logic [2:0]                     forward_detect_rs1,
    input  logic [2:0]                     forward_detect_rs2,
    input  logic [DATA_WIDTH-1:0]          alu_res_MEM,
    input  logic [DATA_WIDTH-1:0]          result_WB,
    output logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX,
    output logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    output logic [1:0]                     result_sel_EX,
    output logic                           PC_take_branch_EX,
    output logic                           PC_take_jalr_EX,
    output logic [INST_ADDR_WIDTH-1:0]     PC_for_normal_branch_EX,
    output logic [INST_ADDR_WIDTH-1:0]     PC_for_jalr_EX,
    output logic                           reg_write_EX_MEM_o,
    output logic                           mem_write_EX_MEM_o,
    output logic [1:0]                     result_sel_EX_MEM_o,
    output logic [2:0]                     funct3_EX_MEM_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
    output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
    output logic [DATA_WIDTH-1:0]          write_data_EX_MEM_o,
    output logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o
);

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0]     pc;
        logic [INST_ADDR_WIDTH-1:0]     pc_plus_4;
        logic [REGISTER_ADDR_WIDTH-1:0] rs1;
        logic [REGISTER_ADDR_WIDTH-1:0] rs2;
        logic [REGISTER_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]          imm;
        logic [DATA_WIDTH-1:0]          rd1;
        logic [DATA_WIDTH-1:0]          rd2;
        logic                           reg_write;
        logic                           mem_write;
        logic                           meet_branch;
        logic                           pc_jal_sel;
        logic [1:0]                     result_sel;
        logic [1:0]                     uncond_jump;
        logic [1:0]                     alu_sel_rs1;
        logic [1:0]                     alu_sel_rs2;
        logic [3:0]                     alu_ctrl;
        logic [2:0]                     funct3;
    } id_ex_t;

    typedef struct packed {
        logic                           reg_write;
        logic                           mem_write;
        logic [1:0]                     result_sel;
        logic [2:0]                     funct3;
        logic [REGISTER_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]          alu_res;
        logic [DATA_WIDTH-1:0]          write_data;
        logic [INST_ADDR_WIDTH-1:0]     pc_plus_4;
    } ex_mem_t;

    id_ex_t  id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;

    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_out, alu_res_ex;
    logic [4:0]            shamt;
    logic                  branch_cond;

    // A flush turns the incoming instruction into an all-zero bubble.
    always_comb begin
        id_ex_d = '0;
        if (!flush_ID_EX) begin
            id_ex_d = '{pc: PC_ID, pc_plus_4: PC_plus_4_ID, rs1: rs1_ID, rs2: rs2_ID,
                        rd: rd_ID, imm: imm_ID, rd1: RD1D_ID, rd2: RD2D_ID,
                        reg_write: reg_write_ID, mem_write: mem_write_ID,
                        meet_branch: meet_branch_ID, pc_jal_sel: pc_jal_sel_ID,
                        result_sel: result_sel_ID, uncond_jump: uncond_jump_ID,
                        alu_sel_rs1: alu_sel_rs1_ID, alu_sel_rs2: alu_sel_rs2_ID,
                        alu_ctrl: alu_ctrl_ID, funct3: funct3_ID};
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    always_comb begin
        unique case (forward_detect_rs1)
            3'd1:    fwd_rs1 = alu_res_MEM;
            3'd2:    fwd_rs1 = result_WB;
            default: fwd_rs1 = id_ex_q.rd1;
        endcase
        unique case (forward_detect_rs2)
            3'd1:    fwd_rs2 = alu_res_MEM;
            3'd2:    fwd_rs2 = result_WB;
            default: fwd_rs2 = id_ex_q.rd2;
        endcase
    end

    always_comb begin
        unique case (id_ex_q.alu_sel_rs1)
            2'd0:    op_a = fwd_rs1;
            2'd1:    op_a = DATA_WIDTH'(id_ex_q.pc);
            default: op_a = '0;
        endcase
        unique case (id_ex_q.alu_sel_rs2)
            2'd0:    op_b = fwd_rs2;
            2'd1:    op_b = id_ex_q.imm;
            2'd2:    op_b = DATA_WIDTH'(4);
            default: op_b = '0;
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = '0;
        case (id_ex_q.alu_ctrl)
            4'd0:    alu_out = op_a + op_b;
            4'd1:    alu_out = op_a - op_b;
            4'd2:    alu_out = op_a << shamt;
            4'd3:    alu_out = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            4'd4:    alu_out = DATA_WIDTH'(op_a < op_b);
            4'd5:    alu_out = op_a ^ op_b;
            4'd6:    alu_out = op_a >> shamt;
            4'd7:    alu_out = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_out = op_a | op_b;
            4'd9:    alu_out = op_a & op_b;
            4'd10:   alu_out = op_b;
            default: alu_out = '0;
        endcase
    end

    // JAL/JALR write the link address rather than the ALU result.
    assign alu_res_ex = id_ex_q.pc_jal_sel ? DATA_WIDTH'(id_ex_q.pc_plus_4) : alu_out;

    always_comb begin
        branch_cond = 1'b0;
        case (id_ex_q.funct3)
            3'b000:  branch_cond = (fwd_rs1 == fwd_rs2);
            3'b001:  branch_cond = (fwd_rs1 != fwd_rs2);
            3'b100:  branch_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            3'b101:  branch_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            3'b110:  branch_cond = (fwd_rs1 <  fwd_rs2);
            3'b111:  branch_cond = (fwd_rs1 >= fwd_rs2);
            default: branch_cond = 1'b0;
        endcase
    end

    assign PC_take_branch_EX = (id_ex_q.meet_branch & branch_cond) |
                               (id_ex_q.uncond_jump == 2'd1);
    assign PC_take_jalr_EX   = (id_ex_q.uncond_jump == 2'd2);
    assign PC_for_normal_branch_EX = id_ex_q.pc + INST_ADDR_WIDTH'(id_ex_q.imm);
    assign PC_for_jalr_EX = INST_ADDR_WIDTH'(fwd_rs1 + id_ex_q.imm) &
                            ~INST_ADDR_WIDTH'(1);

    assign rs1_EX        = id_ex_q.rs1;
    assign rs2_EX        = id_ex_q.rs2;
    assign rd_EX         = id_ex_q.rd;
    assign result_sel_EX = id_ex_q.result_sel;

    always_comb begin
        ex_mem_d = '{reg_write: id_ex_q.reg_write, mem_write: id_ex_q.mem_write,
                     result_sel: id_ex_q.result_sel, funct3: id_ex_q.funct3,
                     rd: id_ex_q.rd, alu_res: alu_res_ex, write_data: fwd_rs2,
                     pc_plus_4: id_ex_q.pc_plus_4};
    end

    assign reg_write_EX_MEM_o  = ex_mem_q.reg_write;
    assign mem_write_EX_MEM_o  = ex_mem_q.mem_write;
    assign result_sel_EX_MEM_o = ex_mem_q.result_sel;
    assign funct3_EX_MEM_o     = ex_mem_q.funct3;
    assign rd_EX_MEM_o         = ex_mem_q.rd;
    assign alu_res_EX_MEM_o    = ex_mem_q.alu_res;
    assign write_data_EX_MEM_o = ex_mem_q.write_data;
    assign PC_plus_4_EX_MEM_o  = ex_mem_q.pc_plus_4;

endmodule

// File: tb/tb_ex_stage_slice.sv
// Directed-vector bench for ex_stage_slice with hand-computed expectations.
module tb_ex_stage_slice;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        flush_ID_EX;
    logic [31:0] PC_ID, PC_plus_4_ID, imm_ID, RD1D_ID, RD2D_ID, alu_res_MEM, result_WB;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic        reg_write_ID, mem_write_ID, meet_branch_ID, pc_jal_sel_ID;
    logic [1:0]  result_sel_ID, uncond_jump_ID, alu_sel_rs1_ID, alu_sel_rs2_ID;
    logic [3:0]  alu_ctrl_ID;
    logic [2:0]  funct3_ID, forward_detect_rs1, forward_detect_rs2;

    logic [4:0]  rs1_EX, rs2_EX, rd_EX, rd_EX_MEM_o;
    logic [1:0]  result_sel_EX, result_sel_EX_MEM_o;
    logic        PC_take_branch_EX, PC_take_jalr_EX;
    logic [31:0] PC_for_normal_branch_EX, PC_for_jalr_EX;
    logic        reg_write_EX_MEM_o, mem_write_EX_MEM_o;
    logic [2:0]  funct3_EX_MEM_o;
    logic [31:0] alu_res_EX_MEM_o, write_data_EX_MEM_o, PC_plus_4_EX_MEM_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ex_stage_slice dut (
        .cpu_clk                 (cpu_clk),
        .cpu_rst_n               (cpu_rst_n),
        .flush_ID_EX             (flush_ID_EX),
        .PC_ID                   (PC_ID),
        .PC_plus_4_ID            (PC_plus_4_ID),
        .rs1_ID                  (rs1_ID),
        .rs2_ID                  (rs2_ID),
        .rd_ID                   (rd_ID),
        .imm_ID                  (imm_ID),
        .RD1D_ID                 (RD1D_ID),
        .RD2D_ID                 (RD2D_ID),
        .reg_write_ID            (reg_write_ID),
        .mem_write_ID            (mem_write_ID),
        .meet_branch_ID          (meet_branch_ID),
        .pc_jal_sel_ID           (pc_jal_sel_ID),
        .result_sel_ID           (result_sel_ID),
        .uncond_jump_ID          (uncond_jump_ID),
        .alu_sel_rs1_ID          (alu_sel_rs1_ID),
        .alu_sel_rs2_ID          (alu_sel_rs2_ID),
        .alu_ctrl_ID             (alu_ctrl_ID),
        .funct3_ID               (funct3_ID),
        .forward_detect_rs1      (forward_detect_rs1),
        .forward_detect_rs2      (forward_detect_rs2),
        .alu_res_MEM             (alu_res_MEM),
        .result_WB               (result_WB),
        .rs1_EX                  (rs1_EX),
        .rs2_EX                  (rs2_EX),
        .rd_EX                   (rd_EX),
        .result_sel_EX           (result_sel_EX),
        .PC_take_branch_EX       (PC_take_branch_EX),
        .PC_take_jalr_EX         (PC_take_jalr_EX),
        .PC_for_normal_branch_EX (PC_for_normal_branch_EX),
        .PC_for_jalr_EX          (PC_for_jalr_EX),
        .reg_write_EX_MEM_o      (reg_write_EX_MEM_o),
        .mem_write_EX_MEM_o      (mem_write_EX_MEM_o),
        .result_sel_EX_MEM_o     (result_sel_EX_MEM_o),
        .funct3_EX_MEM_o         (funct3_EX_MEM_o),
        .rd_EX_MEM_o             (rd_EX_MEM_o),
        .alu_res_EX_MEM_o        (alu_res_EX_MEM_o),
        .write_data_EX_MEM_o     (write_data_EX_MEM_o),
        .PC_plus_4_EX_MEM_o      (PC_plus_4_EX_MEM_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_ID_EX = 0; PC_ID = 0; PC_plus_4_ID = 0; imm_ID = 0; RD1D_ID = 0; RD2D_ID = 0;
        rs1_ID = 0; rs2_ID = 0; rd_ID = 0; reg_write_ID = 0; mem_write_ID = 0;
        meet_branch_ID = 0; pc_jal_sel_ID = 0; result_sel_ID = 0; uncond_jump_ID = 0;
        alu_sel_rs1_ID = 0; alu_sel_rs2_ID = 0; alu_ctrl_ID = 0; funct3_ID = 0;
        forward_detect_rs1 = 0; forward_detect_rs2 = 0; alu_res_MEM = 0; result_WB = 0;
    endtask

    // Move one edge forward and sample just after it.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        cpu_rst_n = 0;
        #12;
        check("rst_reg_write", {31'b0, reg_write_EX_MEM_o}, 32'h0);
        check("rst_alu_res", alu_res_EX_MEM_o, 32'h0);
        check("rst_take_branch", {31'b0, PC_take_branch_EX}, 32'h0);
        cpu_rst_n = 1;

        // ADD with rs1 forwarded from MEM: 100 + 7
        RD1D_ID = 5; RD2D_ID = 7; forward_detect_rs1 = 1; alu_res_MEM = 100;
        rs1_ID = 1; rs2_ID = 2; rd_ID = 9; reg_write_ID = 1; result_sel_ID = 2;
        tick();
        check("add_rd_EX", {27'b0, rd_EX}, 32'd9);
        check("add_rs2_EX", {27'b0, rs2_EX}, 32'd2);
        check("add_result_sel_EX", {30'b0, result_sel_EX}, 32'd2);
        tick();
        check("add_alu_res", alu_res_EX_MEM_o, 32'd107);
        check("add_reg_write", {31'b0, reg_write_EX_MEM_o}, 32'h1);
        check("add_rd_mem", {27'b0, rd_EX_MEM_o}, 32'd9);

        // SRA by immediate 4
        clear_inputs();
        RD1D_ID = 32'h8000_0000; imm_ID = 4; alu_sel_rs2_ID = 1; alu_ctrl_ID = 7;
        tick(); tick();
        check("sra", alu_res_EX_MEM_o, 32'hF800_0000);

        // SLTU vs SLT on 1 and 0xFFFFFFFF
        clear_inputs();
        RD1D_ID = 1; RD2D_ID = 32'hFFFF_FFFF; alu_ctrl_ID = 4;
        tick(); tick();
        check("sltu", alu_res_EX_MEM_o, 32'h1);
        alu_ctrl_ID = 3;
        tick(); tick();
        check("slt", alu_res_EX_MEM_o, 32'h0);

        // SUB with PC operand, undefined ALU code
        clear_inputs();
        PC_ID = 32'h40; imm_ID = 32'h10; alu_sel_rs1_ID = 1; alu_sel_rs2_ID = 1; alu_ctrl_ID = 1;
        tick(); tick();
        check("sub_pc_imm", alu_res_EX_MEM_o, 32'h30);
        alu_ctrl_ID = 12;
        tick(); tick();
        check("alu_code_12", alu_res_EX_MEM_o, 32'h0);

        // BLT taken, BLTU not taken
        clear_inputs();
        RD1D_ID = 32'hFFFF_FFFF; RD2D_ID = 1; meet_branch_ID = 1; funct3_ID = 3'b100;
        PC_ID = 32'h100; imm_ID = 32'hFFFF_FFF8;
        tick();
        check("blt_taken", {31'b0, PC_take_branch_EX}, 32'h1);
        check("blt_target", PC_for_normal_branch_EX, 32'hF8);
        funct3_ID = 3'b110;
        tick();
        check("bltu_not_taken", {31'b0, PC_take_branch_EX}, 32'h0);

        // JALR with rs1 from WB
        clear_inputs();
        forward_detect_rs1 = 2; result_WB = 32'h2003; RD1D_ID = 32'h1234; imm_ID = 4;
        pc_jal_sel_ID = 1; PC_plus_4_ID = 32'h44; uncond_jump_ID = 2; reg_write_ID = 1;
        tick();
        check("jalr_take", {31'b0, PC_take_jalr_EX}, 32'h1);
        check("jalr_no_branch", {31'b0, PC_take_branch_EX}, 32'h0);
        check("jalr_target", PC_for_jalr_EX, 32'h2006);
        tick();
        check("jalr_link", alu_res_EX_MEM_o, 32'h44);
        check("jalr_pc4", PC_plus_4_EX_MEM_o, 32'h44);

        // Store with WB-forwarded data, then a flushed store behind it
        clear_inputs();
        mem_write_ID = 1; reg_write_ID = 1; forward_detect_rs2 = 2; result_WB = 32'h55;
        RD2D_ID = 32'h99; funct3_ID = 3'b010; meet_branch_ID = 1; uncond_jump_ID = 1;
        tick();
        check("store_branch_pre", {31'b0, PC_take_branch_EX}, 32'h1);
        flush_ID_EX = 1;
        tick();
        check("store_mem_write", {31'b0, mem_write_EX_MEM_o}, 32'h1);
        check("store_data", write_data_EX_MEM_o, 32'h55);
        check("store_funct3", {29'b0, funct3_EX_MEM_o}, 32'h2);
        check("flush_branch", {31'b0, PC_take_branch_EX}, 32'h0);
        check("flush_jalr", {31'b0, PC_take_jalr_EX}, 32'h0);
        tick();
        check("flush_mem_write", {31'b0, mem_write_EX_MEM_o}, 32'h0);
        check("flush_reg_write", {31'b0, reg_write_EX_MEM_o}, 32'h0);

        // Fwd code 5 selects register data; reset mid-stream clears everything at once
        clear_inputs();
        forward_detect_rs1 = 5; alu_res_MEM = 32'h77; RD1D_ID = 32'h21; alu_ctrl_ID = 0;
        reg_write_ID = 1; rd_ID = 3; uncond_jump_ID = 1; PC_plus_4_ID = 32'h10;
        tick(); tick();
        check("fwd5_alu_res", alu_res_EX_MEM_o, 32'h21);
        check("pre_rst_take", {31'b0, PC_take_branch_EX}, 32'h1);
        #2 cpu_rst_n = 0;
        #1;
        check("mid_rst_reg_write", {31'b0, reg_write_EX_MEM_o}, 32'h0);
        check("mid_rst_alu_res", alu_res_EX_MEM_o, 32'h0);
        check("mid_rst_rd", {27'b0, rd_EX_MEM_o}, 32'h0);
        check("mid_rst_pc4", PC_plus_4_EX_MEM_o, 32'h0);
        check("mid_rst_take_branch", {31'b0, PC_take_branch_EX}, 32'h0);
        check("mid_rst_take_jalr", {31'b0, PC_take_jalr_EX}, 32'h0);
        tick();
        check("rst_dominates", {27'b0, rd_EX}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage_slice.md
Name: ex_stage_slice

Overview:
Execute slice of the five-stage RV32I core. It holds the ID/EX pipeline register, the EX datapath (operand forwarding, operand select, ALU, branch/jump resolution) and the EX/MEM pipeline register. It sits between the decode datapath/regfile and the MEM datapath, and feeds the PC mux, hazard detection and forwarding detection.

Parameters:
DATA_WIDTH, 32, operand/result width
INST_ADDR_WIDTH, 32, PC width
REGISTER_ADDR_WIDTH, 5, register index width

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rst_n  in  1  reset, asynchronous, active-low
flush_ID_EX  in  1  synchronous bubble insert into ID/EX
PC_ID, PC_plus_4_ID  in  INST_ADDR_WIDTH each  instruction PC and PC+4
rs1_ID, rs2_ID, rd_ID  in  REGISTER_ADDR_WIDTH each  register indices
imm_ID, RD1D_ID, RD2D_ID  in  DATA_WIDTH each  signed immediate; regfile read data
reg_write_ID, mem_write_ID, meet_branch_ID, pc_jal_sel_ID  in  1 each  decode controls
result_sel_ID, uncond_jump_ID, alu_sel_rs1_ID, alu_sel_rs2_ID  in  2 each  decode controls
alu_ctrl_ID  in  4;  funct3_ID  in  3
forward_detect_rs1, forward_detect_rs2  in  3 each  forwarding selects
alu_res_MEM, result_WB  in  DATA_WIDTH each  forwarding sources
rs1_EX, rs2_EX, rd_EX  out  REGISTER_ADDR_WIDTH each  ID/EX register copies
result_sel_EX  out  2  ID/EX copy, used for load-use detection
PC_take_branch_EX, PC_take_jalr_EX  out  1 each  redirect requests
PC_for_normal_branch_EX, PC_for_jalr_EX  out  INST_ADDR_WIDTH each  redirect targets
reg_write_EX_MEM_o, mem_write_EX_MEM_o  out  1 each
result_sel_EX_MEM_o  out  2;  funct3_EX_MEM_o  out  3;  rd_EX_MEM_o  out  REGISTER_ADDR_WIDTH
alu_res_EX_MEM_o, write_data_EX_MEM_o  out  DATA_WIDTH;  PC_plus_4_EX_MEM_o  out  INST_ADDR_WIDTH

Behaviour:
- ID/EX register: on each posedge, captures all *_ID inputs.
  - If flush_ID_EX=1, every field loads 0 instead. This is a bubble: no write, no branch, no jump.
  - No stall input.
- EX/MEM register: captures EX results every posedge. No stall or flush input.
- Reset: cpu_rst_n=0 asynchronously clears both registers to 0. Reset dominates flush.
- Combinational outputs are therefore: PC_take_*=0, targets = imm/PC based on zeros, rs*_EX/rd_EX=0, result_sel_EX=0.
- Forwarding (separately for rs1 and rs2), fwd = forward_detect value:
  - 0: ID/EX RD1D/RD2D.
  - 1: alu_res_MEM.
  - 2: result_WB.
  - 3..7: ID/EX RD value.
- Operand A by alu_sel_rs1: 0 = fwd_rs1, 1 = PC, 2/3 = 0.
- Operand B by alu_sel_rs2: 0 = fwd_rs2, 1 = imm, 2 = 4, 3 = 0.
- ALU by alu_ctrl, all results 32-bit wrap:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B.
  - Codes 11..15 give 0.
  - Shift amount = B[4:0].
- alu_res_EX = ALU result, except pc_jal_sel=1 forces alu_res_EX = PC_plus_4 (link value).
- Branch condition on fwd_rs1 vs fwd_rs2, by funct3:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - Other codes never taken.
- PC_take_branch_EX = (meet_branch & cond) | (uncond_jump==1, JAL).
- PC_take_jalr_EX = (uncond_jump==2). uncond_jump==3 means no jump.
- PC_for_normal_branch_EX = PC + imm.
- PC_for_jalr_EX = (fwd_rs1 + imm) with bit 0 cleared.
- write_data_EX = fwd_rs2, i.e. stores use forwarded data.
- EX/MEM captures reg_write, mem_write, result_sel, alu_res_EX, rd, write_data_EX, PC_plus_4, funct3 from the ID/EX copies. Latency is one cycle, EX to MEM outputs.
- A flushed instruction reaching EX/MEM has reg_write=0 and mem_write=0.

Test Plan:
- Reset: assert cpu_rst_n=0 mid-stream -> all EX_MEM outputs 0 immediately, PC_take_branch_EX=0 and PC_take_jalr_EX=0.
- ADD with forwarding: RD1D=5, RD2D=7, fwd_rs1=1 with alu_res_MEM=100, alu_sel=0/0, alu_ctrl=0 -> alu_res_EX_MEM_o=107 two edges after the ID inputs are presented.
- SRA/SLTU: A=0x80000000, B=imm=4, alu_ctrl=7 -> 0xF8000000. alu_ctrl=4 with A=1, B=0xFFFFFFFF -> 1.
- Branch: BLT (funct3=100), meet_branch=1, rs1=-1, rs2=1, PC=0x100, imm=-8 -> PC_take_branch_EX=1, target 0xF8. BLTU with the same operands -> not taken.
- JALR: uncond_jump=2, fwd_rs1 from result_WB=0x2003, imm=4, pc_jal_sel=1, PC_plus_4=0x44 -> PC_take_jalr_EX=1, PC_for_jalr_EX=0x2006, alu_res_EX_MEM_o=0x44.
- Flush: store (mem_write=1) with flush_ID_EX=1 at the capture edge -> next cycle branch/jump outputs are 0; following edge mem_write_EX_MEM_o=0 and reg_write_EX_MEM_o=0.
